// File: rtl/gemm_tile_pkg.sv
// rtl/gemm_tile_pkg.sv - shared types and constants for the GEMM tile mover
package gemm_tile_pkg;

  localparam int ROW_BYTES = 16;

  typedef logic [ROW_BYTES-1:0][7:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

endpackage

// File: rtl/tile_fifo.sv
// rtl/tile_fifo.sv - synchronous FIFO with occupancy count
module tile_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the same cycle, so a full FIFO may still accept.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/gemm_tile_mover.sv
// rtl/gemm_tile_mover.sv - strided tile load/store engine on the wide memory port
module gemm_tile_mover #(
  parameter int ROW_BYTES  = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_ROWS_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cfg_dir,
  input  logic [31:0]            cfg_base,
  input  logic [31:0]            cfg_stride,
  input  logic [MAX_ROWS_W-1:0]  cfg_rows,
  input  logic [4:0]             cfg_bytes,
  output logic                   busy,
  output logic                   done,
  output logic                   interface_en,
  output logic                   interface_rdwr,
  output logic [4:0]             interface_control,
  output logic [31:0]            interface_addr,
  output logic [ROW_BYTES*8-1:0] interface_wr_data,
  input  logic [ROW_BYTES*8-1:0] interface_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROW_BYTES*8-1:0] out_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROW_BYTES*8-1:0] in_data
);

  import gemm_tile_pkg::*;

  localparam int DW = ROW_BYTES * 8;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           stride_q;
  logic [MAX_ROWS_W-1:0] rows_q;
  logic [4:0]            bytes_q;
  logic [MAX_ROWS_W-1:0] issued_q, issued_d;
  logic [MAX_ROWS_W-1:0] popped_q, popped_d;
  logic [MAX_ROWS_W-1:0] written_q, written_d;
  logic                  inflight_q, inflight_d;

  logic                  rd_issue;
  logic                  wr_accept;
  logic                  pop;
  logic                  credit_ok;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;
  logic [DW-1:0]         fifo_head;
  logic [MAX_ROWS_W-1:0] popped_next;

  tile_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_load_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (interface_rd_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // The returning beat is offered directly when the FIFO is empty, giving
  // one-cycle read-to-valid latency and full throughput at depth 2.
  assign out_valid = !fifo_empty || inflight_q;
  assign out_data  = !fifo_empty ? fifo_head : (inflight_q ? interface_rd_data : '0);
  assign pop       = out_valid && out_ready;
  assign fifo_pop  = out_ready && !fifo_empty;
  assign fifo_push = inflight_q && !(fifo_empty && out_ready);

  assign credit_ok   = (fifo_count + CW'(inflight_q)) < CW'(FIFO_DEPTH);
  assign rd_issue    = (state_q == LOAD) && (issued_q < rows_q) && credit_ok;
  assign in_ready    = (state_q == STORE) && (written_q < rows_q);
  assign wr_accept   = in_valid && in_ready;
  assign popped_next = popped_q + MAX_ROWS_W'(pop);

  assign interface_en      = rd_issue || wr_accept;
  assign interface_rdwr    = wr_accept;
  assign interface_control = interface_en ? bytes_q : 5'd0;
  assign interface_addr    = interface_en ? addr_q : 32'd0;
  assign interface_wr_data = wr_accept ? in_data : '0;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    written_d  = written_q;
    inflight_d = rd_issue;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = cfg_base;
          issued_d  = '0;
          popped_d  = '0;
          written_d = '0;
          if (cfg_rows == '0)          state_d = DONE;
          else if (cfg_dir == DIR_STORE) state_d = STORE;
          else                          state_d = LOAD;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        popped_d = popped_next;
        if (rd_issue) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + MAX_ROWS_W'(1);
        end
        if ((issued_q == rows_q) && (popped_next == rows_q)) state_d = DONE;
      end
      STORE: begin
        busy = 1'b1;
        if (wr_accept) begin
          addr_d    = addr_q + stride_q;
          written_d = written_q + MAX_ROWS_W'(1);
          if (written_q + MAX_ROWS_W'(1) == rows_q) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      rows_q     <= '0;
      bytes_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      written_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      written_q  <= written_d;
      inflight_q <= inflight_d;
      if ((state_q == IDLE) && start) begin
        stride_q <= cfg_stride;
        rows_q   <= cfg_rows;
        bytes_q  <= cfg_bytes;
      end
    end
  end

endmodule

// File: tb/tb_gemm_tile_mover.sv
// tb/tb_gemm_tile_mover.sv - scoreboard bench for the GEMM tile mover
module tb_gemm_tile_mover;
  import gemm_tile_pkg::*;

  localparam int RB = ROW_BYTES;
  localparam int DW = RB * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cfg_dir = 1'b0;
  logic [31:0]   cfg_base = '0;
  logic [31:0]   cfg_stride = '0;
  logic [7:0]    cfg_rows = '0;
  logic [4:0]    cfg_bytes = '0;
  logic          busy, done;
  logic          interface_en, interface_rdwr;
  logic [4:0]    interface_control;
  logic [31:0]   interface_addr;
  logic [DW-1:0] interface_wr_data;
  logic [DW-1:0] interface_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;

  gemm_tile_mover #(.ROW_BYTES(RB), .FIFO_DEPTH(2), .MAX_ROWS_W(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .cfg_dir           (cfg_dir),
    .cfg_base          (cfg_base),
    .cfg_stride        (cfg_stride),
    .cfg_rows          (cfg_rows),
    .cfg_bytes         (cfg_bytes),
    .busy              (busy),
    .done              (done),
    .interface_en      (interface_en),
    .interface_rdwr    (interface_rdwr),
    .interface_control (interface_control),
    .interface_addr    (interface_addr),
    .interface_wr_data (interface_wr_data),
    .interface_rd_data (interface_rd_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int rd_issued = 0, rd_popped = 0, done_cnt = 0, done_base = 0;
  int done_cyc = 0, last_pop_cyc = 0, first_rd_cyc = -1, last_rd_cyc = 0;
  int start_cyc = 0, acc_cyc = 0;
  logic          exp_dir = 1'b0;
  logic [4:0]    exp_ctl = '0;
  logic [31:0]   exp_addr_q [$];
  logic [DW-1:0] exp_rd_q [$];
  logic [DW-1:0] exp_wd_q [$];

  logic [DW-1:0] mem [logic [31:0]];
  logic [DW-1:0] wrow;

  function automatic logic [DW-1:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] rnd_row();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory model: read data one cycle after the request, byte-masked writes.
  always @(posedge clk) begin
    if (interface_en && !interface_rdwr) interface_rd_data <= mem_rd(interface_addr);
    if (interface_en && interface_rdwr) begin
      wrow = mem_rd(interface_addr);
      for (int b = 0; b < RB; b++)
        if (b < int'(interface_control)) wrow[b*8 +: 8] = interface_wr_data[b*8 +: 8];
      mem[interface_addr] = wrow;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (interface_en) begin
        if (exp_addr_q.size() == 0) begin
          chk_eq("spurious_en", 1, 0);
        end else begin
          chk_eq("req_addr", interface_addr, exp_addr_q.pop_front());
          chk_eq("req_dir", interface_rdwr, exp_dir);
          chk_eq("req_ctl", interface_control, exp_ctl);
          if (interface_rdwr) begin
            if (exp_wd_q.size() == 0) chk_eq("wr_data_missing", 1, 0);
            else chk_eq("wr_data", interface_wr_data, exp_wd_q.pop_front());
          end else begin
            chk_eq("rd_credit", (rd_issued - rd_popped) < 2, 1);
            if (rd_issued == 0) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
            rd_issued++;
          end
        end
      end
      if (out_valid && out_ready) begin
        if (exp_rd_q.size() == 0) chk_eq("spurious_pop", 1, 0);
        else chk_eq("out_data", out_data, exp_rd_q.pop_front());
        rd_popped++;
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_cmd(input logic dir, input logic [31:0] base, input logic [31:0] stride,
                           input logic [7:0] rows, input logic [4:0] nbytes);
    logic [31:0] a;
    exp_dir = dir;
    exp_ctl = nbytes;
    rd_issued = 0;
    rd_popped = 0;
    first_rd_cyc = -1;
    if (dir == DIR_LOAD) begin
      for (int k = 0; k < int'(rows); k++) begin
        a = base + 32'(k) * stride;
        exp_addr_q.push_back(a);
        exp_rd_q.push_back(mem_rd(a));
      end
    end
    cfg_dir = dir;
    cfg_base = base;
    cfg_stride = stride;
    cfg_rows = rows;
    cfg_bytes = nbytes;
    done_base = done_cnt;
    start_cyc = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_dir = ~dir;
    cfg_base = $urandom;
    cfg_stride = $urandom;
    cfg_rows = 8'($urandom);
    cfg_bytes = 5'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk_eq(tag, done_cnt - done_base, 1);
  endtask

  task automatic drive_beat(input logic [31:0] a, input logic [DW-1:0] d);
    int n = 0;
    exp_addr_q.push_back(a);
    exp_wd_q.push_back(d);
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_eq("beat_accept", in_ready, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = rnd_row();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d3 [3];
    logic [DW-1:0] old_row, new_row, exp_row;

    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_en", interface_en, 0);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-rate load.
    for (int k = 0; k < 4; k++) mem[32'h100 + 32'(k) * 32'h40] = rnd_row();
    out_ready = 1'b1;
    start_cmd(DIR_LOAD, 32'h100, 32'h40, 8'd4, 5'd16);
    wait_done("t1_done", 50);
    chk_eq("t1_first_rd_lat", first_rd_cyc - start_cyc, 1);
    chk_eq("t1_rd_span", last_rd_cyc - first_rd_cyc, 3);
    chk_eq("t1_rd_count", rd_issued, 4);
    chk_eq("t1_pop_count", rd_popped, 4);
    chk_eq("t1_done_lat", done_cyc - last_pop_cyc, 1);
    chk_eq("t1_rd_left", exp_rd_q.size(), 0);

    // Throttled load with an ignored start in the middle.
    for (int k = 0; k < 6; k++) mem[32'h2000 + 32'(k) * 32'h30] = rnd_row();
    start_cmd(DIR_LOAD, 32'h2000, 32'h30, 8'd6, 5'd16);
    for (int k = 0; k < 200 && done_cnt == done_base; k++) begin
      out_ready = (k % 3 == 0);
      if (k == 3) begin
        start = 1'b1;
        cfg_dir = DIR_STORE;
        cfg_base = 32'h9000;
        cfg_rows = 8'd9;
        cfg_bytes = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_eq("t2_done", done_cnt - done_base, 1);
    chk_eq("t2_rd_count", rd_issued, 6);
    chk_eq("t2_pop_count", rd_popped, 6);
    chk_eq("t2_rd_left", exp_rd_q.size() + exp_addr_q.size(), 0);
    chk_eq("t2_in_ready", in_ready, 0);

    // Gapped store across the 32-bit address wrap.
    start_cmd(DIR_STORE, 32'hFFFF_FFE0, 32'h10, 8'd3, 5'd16);
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(posedge clk);
      #1;
      d3[k] = rnd_row();
      drive_beat(32'hFFFF_FFE0 + 32'(k) * 32'h10, d3[k]);
    end
    wait_done("t3_done", 20);
    chk_eq("t3_done_lat", done_cyc - acc_cyc, 1);
    for (int k = 0; k < 3; k++)
      chk_eq("t3_mem", mem_rd(32'hFFFF_FFE0 + 32'(k) * 32'h10), d3[k]);
    chk_eq("t3_wrap_row", mem_rd(32'h0), d3[2]);

    // Zero-row commands, plus a start landing in the DONE cycle.
    start_cmd(DIR_LOAD, 32'h100, 32'h40, 8'd0, 5'd16);
    chk_eq("t4_done_load", done, 1);
    chk_eq("t4_busy_load", busy, 0);
    start = 1'b1;
    cfg_dir = DIR_LOAD;
    cfg_rows = 8'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_eq("t4_idle_done", done, 0);
    @(posedge clk);
    #1;
    chk_eq("t4_ignored_start", done, 0);
    chk_eq("t4_done_count", done_cnt - done_base, 1);
    start_cmd(DIR_STORE, 32'h500, 32'h10, 8'd0, 5'd16);
    chk_eq("t4_done_store", done, 1);
    chk_eq("t4_busy_store", busy, 0);
    @(posedge clk);
    #1;

    // Partial-row store: only the low cfg_bytes bytes may change.
    old_row = rnd_row();
    mem[32'h800] = old_row;
    start_cmd(DIR_STORE, 32'h800, 32'h10, 8'd1, 5'd5);
    new_row = rnd_row();
    drive_beat(32'h800, new_row);
    wait_done("t5_done", 20);
    exp_row = old_row;
    exp_row[39:0] = new_row[39:0];
    chk_eq("t5_mem_masked", mem_rd(32'h800), exp_row);

    // Asynchronous reset during the second read of a load.
    for (int k = 0; k < 4; k++) mem[32'h3000 + 32'(k) * 32'h10] = rnd_row();
    out_ready = 1'b0;
    start_cmd(DIR_LOAD, 32'h3000, 32'h10, 8'd4, 5'd16);
    @(posedge clk);
    #1;
    chk_eq("t6_pre_en", interface_en, 1);
    chk_eq("t6_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_eq("t6_rst_en", interface_en, 0);
    chk_eq("t6_rst_valid", out_valid, 0);
    chk_eq("t6_rst_busy", busy, 0);
    exp_addr_q.delete();
    exp_rd_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("t6_no_done", done_cnt - done_base, 0);
    out_ready = 1'b1;
    start_cmd(DIR_LOAD, 32'h3000, 32'h10, 8'd2, 5'd16);
    wait_done("t6_restart_done", 30);
    chk_eq("t6_restart_pops", rd_popped, 2);
    chk_eq("t6_restart_left", exp_rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
